period_meter: RTL and testbench



---
 rtl/period_meter_pkg.sv | 11 +
 rtl/level_debounce.sv | 52 +++++
 rtl/period_meter.sv | 158 +++++++++++++++
 tb/tb_period_meter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// period_meter_pkg
// Shared types for the period meter.
//   pm_state_t : hysteresis FSM state, also driven out on the debug `state` port.
package period_meter_pkg;

  typedef enum logic [1:0] {
    S_WAIT_LOW  = 2'd0,
    S_WAIT_HIGH = 2'd1
  } pm_state_t;

endpackage

// File: rtl/level_debounce.sv
// level_debounce
// Counts consecutive strobed samples that lie strictly beyond a threshold and
// pulses `hit_o` on the DEBOUNCE-th one.
// Ports:
//   clk, reset_p  : clock, synchronous active-high reset
//   sample_i      : signed sample
//   strobe_i      : sample valid; only strobed cycles advance the count
//   threshold_i   : signed threshold
//   above_i       : 1 = qualify when sample > threshold, 0 = when sample < threshold
//   clear_i       : clears the run count (used on level change)
//   hit_o         : combinational pulse on the DEBOUNCE-th consecutive qualifying sample
module level_debounce #(
  parameter int unsigned DEBOUNCE = 16,
  parameter int unsigned W_DATA   = 16
) (
  input  logic                     clk,
  input  logic                     reset_p,
  input  logic signed [W_DATA-1:0] sample_i,
  input  logic                     strobe_i,
  input  logic signed [W_DATA-1:0] threshold_i,
  input  logic                     above_i,
  input  logic                     clear_i,
  output logic                     hit_o
);

  // The count never needs to hold DEBOUNCE itself: the hit fires on DEBOUNCE-1.
  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0] count_q, count_d;
  logic          qual;

  always_comb begin
    qual    = above_i ? (sample_i > threshold_i) : (sample_i < threshold_i);
    hit_o   = strobe_i && qual && (count_q == LAST);
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (strobe_i) begin
      count_d = qual ? count_q + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/period_meter.sv
// period_meter
// Measures the period of a sampled waveform (in samples) using two-threshold
// hysteresis with debouncing, averages 2^AVG_LOG2 periods and flags signal loss.
// Ports:
//   clk, reset_p                : clock, synchronous active-high reset
//   data, data_we               : signed sample and its strobe
//   threshold_high/low          : signed hysteresis thresholds (low < high)
//   period, period_valid        : last measured period, one-cycle update pulse
//   avg_period, avg_valid       : mean of last completed window, one-cycle pulse
//   signal_lost                 : counter saturated without a qualifying edge
//   state                       : FSM state for debug display
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned W_DATA   = 16,
  parameter int unsigned W_CNT    = 16,
  parameter int unsigned DEBOUNCE = 16,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     reset_p,
  input  logic signed [W_DATA-1:0] data,
  input  logic                     data_we,
  input  logic signed [W_DATA-1:0] threshold_high,
  input  logic signed [W_DATA-1:0] threshold_low,
  output logic [W_CNT-1:0]         period,
  output logic                     period_valid,
  output logic [W_CNT-1:0]         avg_period,
  output logic                     avg_valid,
  output logic                     signal_lost,
  output logic [1:0]               state
);

  localparam int unsigned W_ACC = W_CNT + AVG_LOG2;
  localparam int unsigned W_WIN = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [W_CNT-1:0] CNT_MAX  = '1;
  localparam logic [W_WIN-1:0] WIN_LAST = W_WIN'((1 << AVG_LOG2) - 1);

  pm_state_t          state_q, state_d;
  logic [W_CNT-1:0]   cnt_q, cnt_d;
  logic               armed_q, armed_d;
  logic               lost_q, lost_d;
  logic [W_ACC-1:0]   acc_q, acc_d;
  logic [W_WIN-1:0]   win_q, win_d;
  logic [W_CNT-1:0]   period_q, period_d;
  logic               pv_q, pv_d;
  logic [W_CNT-1:0]   avg_q, avg_d;
  logic               av_q, av_d;

  logic                     hit;
  logic                     qual_edge;
  logic                     above_sel;
  logic signed [W_DATA-1:0] thr_sel;
  logic [W_CNT-1:0]         cnt_inc;
  logic [W_ACC-1:0]         acc_sum;

  // One debouncer serves both levels; threshold and polarity follow the state.
  // A hit always changes state, so it also clears the run count.
  level_debounce #(
    .DEBOUNCE(DEBOUNCE),
    .W_DATA  (W_DATA)
  ) u_debounce (
    .clk        (clk),
    .reset_p    (reset_p),
    .sample_i   (data),
    .strobe_i   (data_we),
    .threshold_i(thr_sel),
    .above_i    (above_sel),
    .clear_i    (hit),
    .hit_o      (hit)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    lost_d   = lost_q;
    acc_d    = acc_q;
    win_d    = win_q;
    period_d = period_q;
    pv_d     = 1'b0;
    avg_d    = avg_q;
    av_d     = 1'b0;

    above_sel = (state_q == S_WAIT_HIGH);
    thr_sel   = above_sel ? threshold_high : threshold_low;
    qual_edge = hit && (state_q == S_WAIT_HIGH);
    cnt_inc   = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    acc_sum   = acc_q + W_ACC'(cnt_inc);

    if (data_we) begin
      if (hit) begin
        state_d = (state_q == S_WAIT_LOW) ? S_WAIT_HIGH : S_WAIT_LOW;
      end
      // An edge on the saturating sample takes priority over loss detection.
      if (qual_edge) begin
        cnt_d   = '0;
        armed_d = 1'b1;
        lost_d  = 1'b0;
        if (armed_q) begin
          period_d = cnt_inc;
          pv_d     = 1'b1;
          if (win_q == WIN_LAST) begin
            avg_d = W_CNT'(acc_sum >> AVG_LOG2);
            av_d  = 1'b1;
            acc_d = '0;
            win_d = '0;
          end else begin
            acc_d = acc_sum;
            win_d = win_q + 1'b1;
          end
        end
      end else begin
        cnt_d = cnt_inc;
        if (cnt_inc == CNT_MAX) begin
          lost_d  = 1'b1;
          armed_d = 1'b0;
          acc_d   = '0;
          win_d   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q  <= S_WAIT_LOW;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      lost_q   <= 1'b0;
      acc_q    <= '0;
      win_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      avg_q    <= '0;
      av_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      lost_q   <= lost_d;
      acc_q    <= acc_d;
      win_q    <= win_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      avg_q    <= avg_d;
      av_q     <= av_d;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;
  assign avg_period   = avg_q;
  assign avg_valid    = av_q;
  assign signal_lost  = lost_q;
  assign state        = state_q;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter
// Drives directed and randomized sample streams into period_meter (default
// parameters, thresholds +/-120) and checks every cycle against a behavioural
// model, plus literal expectations for the known scenarios.
module tb_period_meter;
  import period_meter_pkg::*;

  localparam int DEB  = 16;
  localparam int MAXC = 65535;
  localparam int TH   = 120;
  localparam int TL   = -120;

  logic               clk = 1'b0;
  logic               reset_p;
  logic signed [15:0] data;
  logic               data_we;
  logic signed [15:0] threshold_high;
  logic signed [15:0] threshold_low;
  logic [15:0]        period;
  logic               period_valid;
  logic [15:0]        avg_period;
  logic               avg_valid;
  logic               signal_lost;
  logic [1:0]         state;

  period_meter #(
    .W_DATA  (16),
    .W_CNT   (16),
    .DEBOUNCE(DEB),
    .AVG_LOG2(2)
  ) dut (
    .clk           (clk),
    .reset_p       (reset_p),
    .data          (data),
    .data_we       (data_we),
    .threshold_high(threshold_high),
    .threshold_low (threshold_low),
    .period        (period),
    .period_valid  (period_valid),
    .avg_period    (avg_period),
    .avg_valid     (avg_valid),
    .signal_lost   (signal_lost),
    .state         (state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- behavioural model ----------------
  int m_phase;        // 0: looking for low level, 1: looking for high level
  int m_run;          // consecutive qualifying samples
  int m_cnt;          // samples since last edge, saturating
  bit m_armed;
  bit m_lost;
  int m_win[$];       // published periods in the current averaging window
  int e_period, e_avg;
  bit e_pv, e_av;
  bit model_ok = 1'b0;
  int m_s;
  bit m_q;
  int m_sum;

  always @(posedge clk) begin
    e_pv = 1'b0;
    e_av = 1'b0;
    if (reset_p) begin
      m_phase = 0; m_run = 0; m_cnt = 0; m_armed = 0; m_lost = 0;
      m_win.delete();
      e_period = 0; e_avg = 0;
      model_ok = 1'b1;
    end else if (data_we) begin
      m_s = int'(data);
      m_q = (m_phase == 0) ? (m_s < TL) : (m_s > TH);
      m_run = m_q ? m_run + 1 : 0;
      if (m_cnt < MAXC) m_cnt++;
      if (m_run == DEB) begin
        m_run = 0;
        if (m_phase == 1) begin
          if (m_armed) begin
            e_period = m_cnt;
            e_pv = 1'b1;
            m_win.push_back(m_cnt);
            if (m_win.size() == 4) begin
              m_sum = 0;
              foreach (m_win[i]) m_sum += m_win[i];
              e_avg = m_sum / 4;
              e_av = 1'b1;
              m_win.delete();
            end
          end
          m_armed = 1; m_lost = 0; m_cnt = 0; m_phase = 0;
        end else begin
          m_phase = 1;
        end
      end else if (m_cnt == MAXC) begin
        m_lost = 1; m_armed = 0;
        m_win.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      n_cmp++;
      if (period !== 16'(e_period) || period_valid !== e_pv || avg_period !== 16'(e_avg) ||
          avg_valid !== e_av || signal_lost !== m_lost || state !== 2'(m_phase)) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t: got per=%0d pv=%0b avg=%0d av=%0b lost=%0b st=%0d, want per=%0d pv=%0b avg=%0d av=%0b lost=%0b st=%0d",
                 $time, period, period_valid, avg_period, avg_valid, signal_lost, state,
                 e_period, e_pv, e_avg, e_av, m_lost, m_phase);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int cyc = 0;
  int pv_cnt = 0, av_cnt = 0;
  int last_per = 0, last_avg = 0;
  int pv_cyc[$];

  task automatic cycle(input int d, input bit we);
    data = 16'(d);
    data_we = we;
    @(posedge clk);
    #1;
    cyc++;
    if (period_valid) begin pv_cnt++; last_per = int'(period); pv_cyc.push_back(cyc); end
    if (avg_valid) begin av_cnt++; last_avg = int'(avg_period); end
  endtask

  task automatic run(input int v, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      cycle(v, 1'b1);
      for (int j = 1; j < gap; j++) cycle(int'($urandom), 1'b0);
    end
  endtask

  task automatic clear_stats();
    pv_cnt = 0; av_cnt = 0; pv_cyc.delete();
  endtask

  task automatic do_reset();
    reset_p = 1'b1;
    cycle(0, 1'b0);
    reset_p = 1'b0;
    clear_stats();
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_period"}, int'(period), 0);
    check({tag, "_pv"}, int'(period_valid), 0);
    check({tag, "_avg"}, int'(avg_period), 0);
    check({tag, "_av"}, int'(avg_valid), 0);
    check({tag, "_lost"}, int'(signal_lost), 0);
    check({tag, "_state"}, int'(state), int'(S_WAIT_LOW));
  endtask

  task automatic square(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      run(-1000, 50, gap);
      run(1000, 50, gap);
    end
  endtask

  task automatic band(input int n);
    for (int i = 0; i < n; i++) cycle((i % 2 != 0) ? 100 : -100, 1'b1);
  endtask

  int per_list[4] = '{100, 102, 98, 104};
  int kind, len, v;

  initial begin
    reset_p = 1'b1;
    data = '0;
    data_we = 1'b0;
    threshold_high = 16'(TH);
    threshold_low  = 16'(TL);
    cycle(0, 1'b0);
    do_reset();
    check_reset_outputs("reset");

    // Square wave, strobe every cycle: 6 edges, first unarmed.
    square(6, 1);
    check("sq1_pulses", pv_cnt, 5);
    check("sq1_period", last_per, 100);
    check("sq1_avg_pulses", av_cnt, 1);
    check("sq1_avg", last_avg, 100);

    // Same wave, strobe every 3rd cycle.
    do_reset();
    square(6, 3);
    check("sq3_pulses", pv_cnt, 5);
    check("sq3_period", last_per, 100);
    check("sq3_spacing", pv_cyc[pv_cyc.size()-1] - pv_cyc[pv_cyc.size()-2], 300);

    // Periods 100,102,98,104: interval = previous high length (50) + low length.
    do_reset();
    square(1, 1);
    foreach (per_list[i]) begin
      run(-1000, per_list[i] - 50, 1);
      run(1000, 50, 1);
    end
    check("avg4_pulses", pv_cnt, 4);
    check("avg4_last_period", last_per, 104);
    check("avg4_avg", last_avg, 101);

    // Glitches and in-band samples must not change level.
    do_reset();
    square(1, 1);
    run(1000, 10, 1);
    run(-1000, 10, 1);
    run(1000, 20, 1);
    band(40);
    check("glitch_low_state", int'(state), int'(S_WAIT_LOW));
    check("glitch_low_pulses", pv_cnt, 0);
    run(-1000, 50, 1);
    run(1000, 8, 1);
    run(-1000, 10, 1);
    band(40);
    check("glitch_high_state", int'(state), int'(S_WAIT_HIGH));
    check("glitch_high_pulses", pv_cnt, 0);
    run(1000, 50, 1);
    check("glitch_period", last_per, 238);

    // Reset in the middle of S_WAIT_HIGH, with data_we also high.
    do_reset();
    square(2, 1);
    run(-1000, 50, 1);
    run(1000, 5, 1);
    reset_p = 1'b1;
    cycle(1000, 1'b1);
    reset_p = 1'b0;
    check_reset_outputs("midrst");
    clear_stats();
    square(1, 1);
    check("midrst_unarmed", pv_cnt, 0);
    square(1, 1);
    check("midrst_pulses", pv_cnt, 1);
    check("midrst_period", last_per, 100);

    // Loss of signal discards the partial averaging window.
    do_reset();
    square(3, 1);
    check("lost_pre_pulses", pv_cnt, 2);
    run(0, 65535, 1);
    check("lost_set", int'(signal_lost), 1);
    square(1, 1);
    check("lost_cleared", int'(signal_lost), 0);
    check("lost_edge_unarmed", pv_cnt, 2);
    square(4, 1);
    check("lost_post_pulses", pv_cnt, 6);
    check("lost_post_avg_pulses", av_cnt, 1);
    check("lost_post_avg", last_avg, 100);

    // Randomized segments with occasional mid-stream resets.
    do_reset();
    for (int seg = 0; seg < 250; seg++) begin
      if (seg % 97 == 50) begin
        reset_p = 1'b1;
        cycle(int'($urandom), $urandom_range(0, 1) != 0);
        reset_p = 1'b0;
      end
      kind = int'($urandom_range(0, 5));
      len  = int'($urandom_range(1, 40));
      for (int i = 0; i < len; i++) begin
        case (kind)
          0, 5: v = -int'($urandom_range(121, 32768));
          1:    v = int'($urandom_range(121, 32767));
          2:    v = int'($urandom_range(0, 240)) - 120;
          3:    v = ($urandom_range(0, 1) != 0) ? TH : TL;
          default: v = int'($urandom_range(0, 65535)) - 32768;
        endcase
        if (kind == 5 && (seg % 2) == 0) v = -v;
        cycle(v, $urandom_range(0, 3) != 0);
      end
    end
    n_cmp++;
    if (pv_cnt == 0) begin
      n_bad++;
      $display("FAIL random_activity: got %0d period pulses, expected at least 1", pv_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
